// File: rtl/dp_aux_txn_monitor_if.sv
// ---------------------------------------------------------------------------
// dp_aux_txn_monitor_if
// Bundle of AUX request/reply signals exchanged between NUM_CH policy makers
// and the link layer. The monitor only observes these signals.
//   req_vld  [NUM_CH]    request valid per channel
//   req_cmd  [4*NUM_CH]  command, channel c at [4c+3:4c]
//   req_len  [8*NUM_CH]  LEN field (bytes-1), channel c at [8c+7:8c]
//   ack_vld  [NUM_CH]    reply valid per channel
//   ack_code [2*NUM_CH]  00 ACK, 01 NACK, 10 DEFER, 11 reserved
//   data_vld [NUM_CH]    reply data beat valid per channel
// Modports: master drives the bundle, slave observes it.
// ---------------------------------------------------------------------------
interface dp_aux_txn_monitor_if #(
   parameter int NUM_CH = 2
);
   logic [NUM_CH-1:0]   req_vld;
   logic [4*NUM_CH-1:0] req_cmd;
   logic [8*NUM_CH-1:0] req_len;
   logic [NUM_CH-1:0]   ack_vld;
   logic [2*NUM_CH-1:0] ack_code;
   logic [NUM_CH-1:0]   data_vld;

   modport master (
      output req_vld, req_cmd, req_len, ack_vld, ack_code, data_vld
   );

   modport slave (
      input req_vld, req_cmd, req_len, ack_vld, ack_code, data_vld
   );
endinterface

// File: rtl/dp_aux_txn_monitor.sv
// ---------------------------------------------------------------------------
// dp_aux_txn_monitor
// Passive AUX transaction monitor. Follows one transaction at a time from
// request through reply and read data, and flags protocol violations.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   clr_err          clears sticky flags, first-error capture and counter
//   bus              observed request/reply bundle (slave modport)
//   busy             a transaction is in progress
//   active_ch        channel owning the current (or last) transaction
//   txn_done         one-cycle pulse when a transaction completes
//   err_sticky[9:0]  sticky error flags
//   err_pulse        any error detected in the previous input cycle
//   err_first_code   index of the first error since reset/clear
//   err_first_ch     channel associated with that first error
//   err_count        saturating count of cycles with at least one error
// Error bits: 0 ILLEGAL_CMD, 1 MULTI_REQ, 2 ILLEGAL_ACK, 3 MULTI_REPLY,
//   4 TIMEOUT, 5 DATA_COUNT, 6 NACK_NO_MBYTE, 7 DEFER_LIMIT,
//   8 UNEXPECTED_REPLY, 9 LEN_RANGE.
// ---------------------------------------------------------------------------
module dp_aux_txn_monitor #(
   parameter int                NUM_CH      = 2,
   parameter logic [NUM_CH-1:0] I2C_MASK    = 2'b10,
   parameter int                MAX_LEN     = 16,
   parameter int                TIMEOUT_CYC = 400,
   parameter int                MAX_DEFER   = 7,
   parameter int                CNT_W       = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clr_err,
   dp_aux_txn_monitor_if.slave       bus,
   output logic                      busy,
   output logic [$clog2(NUM_CH)-1:0] active_ch,
   output logic                      txn_done,
   output logic [9:0]                err_sticky,
   output logic                      err_pulse,
   output logic [3:0]                err_first_code,
   output logic [$clog2(NUM_CH)-1:0] err_first_ch,
   output logic [CNT_W-1:0]          err_count
);
   localparam int CHW = $clog2(NUM_CH);
   localparam int TW  = $clog2(TIMEOUT_CYC + 1);
   localparam int DW  = $clog2(MAX_DEFER + 2);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, RD_DATA, NACK_M} state_t;

   state_t         state, state_nxt;
   logic [CHW-1:0] ch_q, ch_nxt;
   logic [3:0]     cmd_q, cmd_nxt;
   logic [7:0]     len_q, len_nxt;
   logic [8:0]     beat_q, beat_nxt;
   logic [TW-1:0]  tmo_q, tmo_nxt;
   logic [DW-1:0]  dfr_q, dfr_nxt;
   logic [CHW-1:0] dfr_ch_q, dfr_ch_nxt;
   logic           done_nxt;
   logic [9:0]     err;
   logic [3:0]     err_code;
   logic [CHW-1:0] err_ch;

   logic [NUM_CH-1:0] own_mask, unexp;
   logic              req_any, req_multi, ack_multi;
   logic [CHW-1:0]    req_ch, ack_lo, unexp_lo;
   logic [3:0]        req_cmd_sel;
   logic [7:0]        req_len_sel;
   logic              act_ack, act_data;
   logic [1:0]        act_code;

   function automatic logic [CHW-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
      lowest_ch = '0;
      for (int i = NUM_CH - 1; i >= 0; i--)
         if (m[i]) lowest_ch = CHW'(i);
   endfunction

   function automatic logic cmd_legal(input logic i2c, input logic [3:0] c);
      if (i2c)
         return (c == 4'b0000) || (c == 4'b0001) || (c == 4'b0010);
      return (c == 4'b1000) || (c == 4'b1001);
   endfunction

   function automatic logic cmd_is_read(input logic [3:0] c);
      return (c == 4'b1001) || (c == 4'b0001);
   endfunction

   // Request/reply decode. A mask AND (mask-1) is nonzero exactly when two or
   // more bits are set. Replies are "unexpected" on any channel while idle and
   // on every channel but the owner while busy.
   always_comb begin
      own_mask       = '0;
      own_mask[ch_q] = 1'b1;
      req_any        = |bus.req_vld;
      req_multi      = |(bus.req_vld & (bus.req_vld - 1'b1));
      ack_multi      = |(bus.ack_vld & (bus.ack_vld - 1'b1));
      req_ch         = lowest_ch(bus.req_vld);
      ack_lo         = lowest_ch(bus.ack_vld);
      req_cmd_sel    = bus.req_cmd[4*req_ch +: 4];
      req_len_sel    = bus.req_len[8*req_ch +: 8];
      act_ack        = bus.ack_vld[ch_q];
      act_data       = bus.data_vld[ch_q];
      act_code       = bus.ack_code[2*ch_q +: 2];
      if (state == IDLE)
         unexp = bus.ack_vld | bus.data_vld;
      else
         unexp = (bus.ack_vld | bus.data_vld) & ~own_mask;
      unexp_lo = lowest_ch(unexp);
   end

   // Transaction FSM next-state logic and per-cycle error detection. Illegal
   // but accepted requests still walk through the FSM so that later reply
   // checks stay meaningful. A reserved reply code is flagged and otherwise
   // ignored, so the timeout keeps running.
   always_comb begin
      state_nxt  = state;
      ch_nxt     = ch_q;
      cmd_nxt    = cmd_q;
      len_nxt    = len_q;
      beat_nxt   = beat_q;
      tmo_nxt    = tmo_q;
      dfr_nxt    = dfr_q;
      dfr_ch_nxt = dfr_ch_q;
      done_nxt   = 1'b0;
      err        = '0;

      err[3] = ack_multi;
      err[8] = |unexp;
      if (state != IDLE && req_any) err[1] = 1'b1;

      case (state)
         IDLE: begin
            if (req_multi) begin
               err[1] = 1'b1;
            end else if (req_any) begin
               state_nxt = WAIT_ACK;
               ch_nxt    = req_ch;
               cmd_nxt   = req_cmd_sel;
               len_nxt   = req_len_sel;
               tmo_nxt   = '0;
               if (!cmd_legal(I2C_MASK[req_ch], req_cmd_sel)) err[0] = 1'b1;
               if ({1'b0, req_len_sel} + 9'd1 > 9'(MAX_LEN)) err[9] = 1'b1;
               if (req_ch != dfr_ch_q) dfr_nxt = '0;
            end
         end

         WAIT_ACK: begin
            if (act_data) err[5] = 1'b1;
            if (act_ack && act_code != 2'b11) begin
               case (act_code)
                  2'b00: begin
                     dfr_nxt = '0;
                     if (cmd_is_read(cmd_q)) begin
                        state_nxt = RD_DATA;
                        beat_nxt  = '0;
                        tmo_nxt   = '0;
                     end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                     end
                  end
                  2'b01: begin
                     dfr_nxt = '0;
                     if (I2C_MASK[ch_q]) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                     end else if (cmd_is_read(cmd_q)) begin
                        err[2]    = 1'b1;
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                     end else begin
                        state_nxt = NACK_M;
                     end
                  end
                  default: begin
                     state_nxt  = IDLE;
                     dfr_ch_nxt = ch_q;
                     if (dfr_q >= DW'(MAX_DEFER)) err[7] = 1'b1;
                     if (dfr_q <= DW'(MAX_DEFER)) dfr_nxt = dfr_q + 1'b1;
                  end
               endcase
            end else begin
               if (act_ack) err[2] = 1'b1;
               if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                  err[4]    = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  tmo_nxt = tmo_q + 1'b1;
               end
            end
         end

         RD_DATA: begin
            if (act_data) begin
               if (beat_q != '1) beat_nxt = beat_q + 1'b1;
               tmo_nxt = '0;
            end else if (beat_q != '0) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
               if (beat_q != {1'b0, len_q} + 9'd1) err[5] = 1'b1;
            end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
               err[4]    = 1'b1;
               state_nxt = IDLE;
            end else begin
               tmo_nxt = tmo_q + 1'b1;
            end
         end

         NACK_M: begin
            state_nxt = IDLE;
            if (act_data) done_nxt = 1'b1;
            else          err[6]   = 1'b1;
         end

         default: state_nxt = IDLE;
      endcase
   end

   // First-error capture: lowest set error index, and the channel that the
   // error is attributed to (requester, replier or transaction owner).
   always_comb begin
      err_code = '0;
      for (int i = 9; i >= 0; i--)
         if (err[i]) err_code = 4'(i);
      case (err_code)
         4'd0, 4'd1, 4'd9: err_ch = req_ch;
         4'd3:             err_ch = ack_lo;
         4'd8:             err_ch = unexp_lo;
         default:          err_ch = ch_q;
      endcase
   end

   // State and context registers plus all registered outputs. Reset wins over
   // clr_err; clr_err wins over errors detected in the same cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         ch_q           <= '0;
         cmd_q          <= '0;
         len_q          <= '0;
         beat_q         <= '0;
         tmo_q          <= '0;
         dfr_q          <= '0;
         dfr_ch_q       <= '0;
         txn_done       <= 1'b0;
         err_pulse      <= 1'b0;
         err_sticky     <= '0;
         err_first_code <= '0;
         err_first_ch   <= '0;
         err_count      <= '0;
      end else begin
         state     <= state_nxt;
         ch_q      <= ch_nxt;
         cmd_q     <= cmd_nxt;
         len_q     <= len_nxt;
         beat_q    <= beat_nxt;
         tmo_q     <= tmo_nxt;
         dfr_q     <= dfr_nxt;
         dfr_ch_q  <= dfr_ch_nxt;
         txn_done  <= done_nxt;
         err_pulse <= |err;
         if (clr_err) begin
            err_sticky     <= '0;
            err_first_code <= '0;
            err_first_ch   <= '0;
            err_count      <= '0;
         end else if (|err) begin
            if (err_sticky == '0) begin
               err_first_code <= err_code;
               err_first_ch   <= err_ch;
            end
            err_sticky <= err_sticky | err;
            if (err_count != '1) err_count <= err_count + 1'b1;
         end
      end
   end

   assign busy      = (state != IDLE);
   assign active_ch = ch_q;
endmodule
